// File: rtl/ddfs_pkg.sv
// ---------------------------------------------------------------------------
// ddfs_pkg
// Shared definitions for the complex-sinusoid DDFS and its sweep controller.
// Keeping the frequency-word width here lets both blocks stay aligned from a
// single source.
//   sweep_state_t    : sweep controller FSM states
//   DDFS_FREQ_WIDTH  : width of the DDFS phase-increment word
//   DDFS_DWELL_WIDTH : default width of the per-step dwell counter
// ---------------------------------------------------------------------------
package ddfs_pkg;

    localparam int DDFS_FREQ_WIDTH  = 32;
    localparam int DDFS_DWELL_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

endpackage : ddfs_pkg

// File: rtl/ddfs_sweep_controller.sv
// ---------------------------------------------------------------------------
// ddfs_sweep_controller
// Stepped frequency-sweep sequencer feeding the DDFS frequency-control word.
// A sweep begins at a start word, adds a fixed step after every dwell period
// and ends once the next word would exceed the stop word (or overflow).
// In repeat mode it restarts from the start word instead of finishing.
//
// Ports:
//   i_clk          : clock, rising edge
//   i_rst          : synchronous active-high reset
//   i_start        : begin a sweep (only honoured in IDLE)
//   i_abort        : end the sweep immediately, highest priority
//   i_start_freq   : first frequency word
//   i_stop_freq    : inclusive upper bound of the sweep
//   i_step         : increment between steps
//   i_dwell        : cycles each word is held (0 behaves as 1)
//   i_repeat       : 1 = loop back to start word, 0 = single shot
//   o_freq_control : registered word for the DDFS i_freq_control
//   o_step_strobe  : pulse in the first cycle of each new word
//   o_busy         : high while in DWELL
//   o_done         : pulse on normal completion
// ---------------------------------------------------------------------------
module ddfs_sweep_controller
    import ddfs_pkg::*;
#(
    parameter int FREQ_WIDTH  = DDFS_FREQ_WIDTH,
    parameter int DWELL_WIDTH = DDFS_DWELL_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [FREQ_WIDTH-1:0]  i_start_freq,
    input  logic [FREQ_WIDTH-1:0]  i_stop_freq,
    input  logic [FREQ_WIDTH-1:0]  i_step,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    input  logic                   i_repeat,
    output logic [FREQ_WIDTH-1:0]  o_freq_control,
    output logic                   o_step_strobe,
    output logic                   o_busy,
    output logic                   o_done
);

    // FSM and output registers
    sweep_state_t           state_q,  state_d;
    logic [FREQ_WIDTH-1:0]  freq_q,   freq_d;
    logic                   strobe_q, strobe_d;
    logic                   busy_q,   busy_d;
    logic                   done_q,   done_d;
    logic [DWELL_WIDTH-1:0] cnt_q,    cnt_d;

    // Configuration latched at start; inputs are ignored afterwards
    logic [FREQ_WIDTH-1:0]  start_cfg_q, start_cfg_d;
    logic [FREQ_WIDTH-1:0]  stop_cfg_q,  stop_cfg_d;
    logic [FREQ_WIDTH-1:0]  step_cfg_q,  step_cfg_d;
    logic [DWELL_WIDTH-1:0] dwell_cfg_q, dwell_cfg_d;
    logic                   repeat_cfg_q, repeat_cfg_d;

    // Next word computed one bit wider so an overflow shows up as a carry
    // rather than silently wrapping through zero.
    logic [FREQ_WIDTH:0]    next_sum;
    logic                   next_ok;
    logic                   dwell_last;

    assign next_sum   = {1'b0, freq_q} + {1'b0, step_cfg_q};
    assign next_ok    = !next_sum[FREQ_WIDTH] &&
                        (next_sum[FREQ_WIDTH-1:0] <= stop_cfg_q);
    // dwell_cfg_q is always >= 1 while in DWELL, so this never underflows there
    assign dwell_last = (cnt_q == dwell_cfg_q - DWELL_WIDTH'(1));

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        freq_d       = freq_q;
        strobe_d     = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cnt_d        = cnt_q;
        start_cfg_d  = start_cfg_q;
        stop_cfg_d   = stop_cfg_q;
        step_cfg_d   = step_cfg_q;
        dwell_cfg_d  = dwell_cfg_q;
        repeat_cfg_d = repeat_cfg_q;

        if (i_abort) begin
            // Abort wins everywhere: back to IDLE, word held, no done pulse
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                    if (i_start) begin
                        start_cfg_d  = i_start_freq;
                        stop_cfg_d   = i_stop_freq;
                        step_cfg_d   = i_step;
                        dwell_cfg_d  = (i_dwell == '0) ? DWELL_WIDTH'(1) : i_dwell;
                        repeat_cfg_d = i_repeat;
                        freq_d       = i_start_freq;
                        strobe_d     = 1'b1;
                        busy_d       = 1'b1;
                        cnt_d        = '0;
                        state_d      = DWELL;
                    end
                end

                DWELL: begin
                    if (!dwell_last) begin
                        cnt_d = cnt_q + DWELL_WIDTH'(1);
                    end else if (next_ok) begin
                        freq_d   = next_sum[FREQ_WIDTH-1:0];
                        strobe_d = 1'b1;
                        cnt_d    = '0;
                    end else if (repeat_cfg_q) begin
                        freq_d   = start_cfg_q;
                        strobe_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end

                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end

                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register updates from the
        // values present before the edge, independent of statement order.
        if (i_rst) begin
            state_q      <= IDLE;
            freq_q       <= '0;
            strobe_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            start_cfg_q  <= '0;
            stop_cfg_q   <= '0;
            step_cfg_q   <= '0;
            dwell_cfg_q  <= '0;
            repeat_cfg_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            freq_q       <= freq_d;
            strobe_q     <= strobe_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
            start_cfg_q  <= start_cfg_d;
            stop_cfg_q   <= stop_cfg_d;
            step_cfg_q   <= step_cfg_d;
            dwell_cfg_q  <= dwell_cfg_d;
            repeat_cfg_q <= repeat_cfg_d;
        end
    end

    assign o_freq_control = freq_q;
    assign o_step_strobe  = strobe_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;

endmodule : ddfs_sweep_controller

// File: tb/tb_ddfs_sweep_controller.sv
// ---------------------------------------------------------------------------
// tb_ddfs_sweep_controller
// Each scenario pushes its expected per-cycle output records into a queue
// while driving stimulus, then pops one record per clock and compares it with
// the DUT outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ddfs_sweep_controller;

    localparam int FW = 32;
    localparam int DW = 16;

    typedef struct {
        logic [FW-1:0] freq;
        logic          strobe;
        logic          busy;
        logic          done;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic          i_abort;
    logic [FW-1:0] i_start_freq;
    logic [FW-1:0] i_stop_freq;
    logic [FW-1:0] i_step;
    logic [DW-1:0] i_dwell;
    logic          i_repeat;
    logic [FW-1:0] o_freq_control;
    logic          o_step_strobe;
    logic          o_busy;
    logic          o_done;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    ddfs_sweep_controller #(.FREQ_WIDTH(FW), .DWELL_WIDTH(DW)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_start_freq   (i_start_freq),
        .i_stop_freq    (i_stop_freq),
        .i_step         (i_step),
        .i_dwell        (i_dwell),
        .i_repeat       (i_repeat),
        .o_freq_control (o_freq_control),
        .o_step_strobe  (o_step_strobe),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [FW-1:0] f, input logic s, input logic b,
                        input logic d);
        exp_t e;
        e.freq = f; e.strobe = s; e.busy = b; e.done = d;
        sb.push_back(e);
    endtask

    // A word held for n cycles while busy, strobe in its first cycle
    task automatic push_word(input logic [FW-1:0] f, input int n);
        for (int k = 0; k < n; k++) push(f, (k == 0), 1'b1, 1'b0);
    endtask

    task automatic set_cfg(input logic [FW-1:0] sf, input logic [FW-1:0] pf,
                           input logic [FW-1:0] st, input logic [DW-1:0] dw,
                           input logic rp);
        i_start_freq = sf; i_stop_freq = pf; i_step = st; i_dwell = dw;
        i_repeat = rp;
    endtask

    task automatic test_reset();
        exp_t e;
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        set_cfg('0, '0, '0, '0, 1'b0);
        push('0, 1'b0, 1'b0, 1'b0);
        push('0, 1'b0, 1'b0, 1'b0);
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick();
            total++;
            if ({o_freq_control, o_step_strobe, o_busy, o_done} !==
                {e.freq, e.strobe, e.busy, e.done}) begin
                bad++;
                $display("FAIL reset: got f=%h s=%b b=%b d=%b want f=%h s=%b b=%b d=%b",
                         o_freq_control, o_step_strobe, o_busy, o_done,
                         e.freq, e.strobe, e.busy, e.done);
            end
        end
        i_rst = 1'b0;
        tick();
    endtask

    // Single-shot sweep; a start pulse while busy must be ignored
    task automatic test_single();
        exp_t e;
        int   idx = 0;
        set_cfg(32'h000F_FFFF, 32'h003F_FFFF, 32'h0010_0000, 16'd4, 1'b0);
        push_word(32'h000F_FFFF, 4);
        push_word(32'h001F_FFFF, 4);
        push_word(32'h002F_FFFF, 4);
        push_word(32'h003F_FFFF, 4);
        push(32'h003F_FFFF, 1'b0, 1'b0, 1'b1);
        push(32'h003F_FFFF, 1'b0, 1'b0, 1'b0);
        push(32'h003F_FFFF, 1'b0, 1'b0, 1'b0);
        i_start = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick();
            idx++;
            i_start = (idx == 5);
            total++;
            if ({o_freq_control, o_step_strobe, o_busy, o_done} !==
                {e.freq, e.strobe, e.busy, e.done}) begin
                bad++;
                $display("FAIL single[%0d]: got f=%h s=%b b=%b d=%b want f=%h s=%b b=%b d=%b",
                         idx, o_freq_control, o_step_strobe, o_busy, o_done,
                         e.freq, e.strobe, e.busy, e.done);
            end
        end
        i_start = 1'b0;
    endtask

    // Repeat sweep with config scrambled mid-sweep, then abort mid-dwell
    task automatic test_repeat_abort();
        exp_t e;
        int   idx = 0;
        set_cfg(32'h000F_FFFF, 32'h003F_FFFF, 32'h0010_0000, 16'd4, 1'b1);
        push_word(32'h000F_FFFF, 4);
        push_word(32'h001F_FFFF, 4);
        push_word(32'h002F_FFFF, 4);
        push_word(32'h003F_FFFF, 4);
        push_word(32'h000F_FFFF, 3);
        i_start = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick();
            idx++;
            i_start = 1'b0;
            if (idx == 2) set_cfg(32'h1234_5678, 32'hFFFF_FFFF, 32'h1, 16'd9, 1'b0);
            total++;
            if ({o_freq_control, o_step_strobe, o_busy, o_done} !==
                {e.freq, e.strobe, e.busy, e.done}) begin
                bad++;
                $display("FAIL repeat[%0d]: got f=%h s=%b b=%b d=%b want f=%h s=%b b=%b d=%b",
                         idx, o_freq_control, o_step_strobe, o_busy, o_done,
                         e.freq, e.strobe, e.busy, e.done);
            end
        end
        i_abort = 1'b1;
        for (int k = 0; k < 4; k++) push(32'h000F_FFFF, 1'b0, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick();
            i_abort = 1'b0;
            total++;
            if ({o_freq_control, o_step_strobe, o_busy, o_done} !==
                {e.freq, e.strobe, e.busy, e.done}) begin
                bad++;
                $display("FAIL abort: got f=%h s=%b b=%b d=%b want f=%h s=%b b=%b d=%b",
                         o_freq_control, o_step_strobe, o_busy, o_done,
                         e.freq, e.strobe, e.busy, e.done);
            end
        end
    endtask

    // Overflow guard, dwell=0, start>stop and start+abort in IDLE
    task automatic test_boundaries();
        exp_t e;
        int   idx = 0;
        // overflow: next word would carry out, so the sweep ends
        set_cfg(32'hFFE0_0000, 32'hFFFF_FFFF, 32'h0010_0000, 16'd1, 1'b0);
        push_word(32'hFFE0_0000, 1);
        push_word(32'hFFF0_0000, 1);
        push(32'hFFF0_0000, 1'b0, 1'b0, 1'b1);
        push(32'hFFF0_0000, 1'b0, 1'b0, 1'b0);
        // dwell=0 acts as 1
        push_word(32'h10, 1);
        push_word(32'h20, 1);
        push_word(32'h30, 1);
        push(32'h30, 1'b0, 1'b0, 1'b1);
        push(32'h30, 1'b0, 1'b0, 1'b0);
        // start together with abort is ignored
        push(32'h30, 1'b0, 1'b0, 1'b0);
        push(32'h30, 1'b0, 1'b0, 1'b0);
        // start > stop: one dwell then done
        push_word(32'h50, 2);
        push(32'h50, 1'b0, 1'b0, 1'b1);
        push(32'h50, 1'b0, 1'b0, 1'b0);
        i_start = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick();
            idx++;
            i_start = 1'b0;
            i_abort = 1'b0;
            if (idx == 4) begin
                set_cfg(32'h10, 32'h30, 32'h10, 16'd0, 1'b0);
                i_start = 1'b1;
            end
            if (idx == 9) begin
                set_cfg(32'h99, 32'hFFFF, 32'h1, 16'd3, 1'b1);
                i_start = 1'b1;
                i_abort = 1'b1;
            end
            if (idx == 11) begin
                set_cfg(32'h50, 32'h40, 32'h1, 16'd2, 1'b0);
                i_start = 1'b1;
            end
            total++;
            if ({o_freq_control, o_step_strobe, o_busy, o_done} !==
                {e.freq, e.strobe, e.busy, e.done}) begin
                bad++;
                $display("FAIL boundary[%0d]: got f=%h s=%b b=%b d=%b want f=%h s=%b b=%b d=%b",
                         idx, o_freq_control, o_step_strobe, o_busy, o_done,
                         e.freq, e.strobe, e.busy, e.done);
            end
        end
    endtask

    // step=0 holds the start word, strobing each dwell, until reset;
    // then a fresh start runs normally
    task automatic test_step0_reset();
        exp_t e;
        int   idx = 0;
        set_cfg(32'h77, 32'h100, 32'h0, 16'd2, 1'b0);
        for (int k = 0; k < 4; k++) push_word(32'h77, 2);
        push('0, 1'b0, 1'b0, 1'b0);
        push('0, 1'b0, 1'b0, 1'b0);
        push_word(32'hA0, 3);
        push_word(32'hB0, 3);
        push(32'hB0, 1'b0, 1'b0, 1'b1);
        push(32'hB0, 1'b0, 1'b0, 1'b0);
        i_start = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tick();
            idx++;
            i_start = 1'b0;
            i_rst   = (idx == 8);
            if (idx == 10) begin
                set_cfg(32'hA0, 32'hB8, 32'h10, 16'd3, 1'b0);
                i_start = 1'b1;
            end
            total++;
            if ({o_freq_control, o_step_strobe, o_busy, o_done} !==
                {e.freq, e.strobe, e.busy, e.done}) begin
                bad++;
                $display("FAIL step0_reset[%0d]: got f=%h s=%b b=%b d=%b want f=%h s=%b b=%b d=%b",
                         idx, o_freq_control, o_step_strobe, o_busy, o_done,
                         e.freq, e.strobe, e.busy, e.done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat_abort();
        test_boundaries();
        test_step0_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ddfs_sweep_controller

// File: doc/ddfs_sweep_controller.md
Name: ddfs_sweep_controller

Overview:
Sequencer that drives the frequency-control word of a complex_sinusoid_ddfs instance. It produces a stepped frequency sweep: start frequency, fixed step, a programmable dwell in clock cycles per step, and a stop frequency. Single-shot and continuous repeat modes are supported. It sits between host/config logic and the DDFS i_freq_control input, and replaces static or testbench-driven frequency words.

Parameters:
FREQ_WIDTH, 32, width of the frequency-control (phase-increment) word.
DWELL_WIDTH, 16, width of the dwell-cycle count.

Ports:
i_clk  input  1  system clock; all logic is on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_start  input  1  begin a sweep; sampled only in IDLE.
i_abort  input  1  terminate the sweep; takes priority over every other input.
i_start_freq  input  FREQ_WIDTH  first frequency word.
i_stop_freq  input  FREQ_WIDTH  upper bound (inclusive) of the sweep.
i_step  input  FREQ_WIDTH  increment between frequency steps.
i_dwell  input  DWELL_WIDTH  cycles each frequency is held; 0 is treated as 1.
i_repeat  input  1  1 = restart from i_start_freq after the last step; 0 = single shot.
o_freq_control  output  FREQ_WIDTH  registered word connected to the DDFS i_freq_control.
o_step_strobe  output  1  one-cycle pulse in the first cycle each new word is presented.
o_busy  output  1  high while a sweep is active (DWELL state).
o_done  output  1  one-cycle pulse at normal sweep completion.

Behaviour:
- Reset (i_rst=1 at a clock edge): state IDLE; o_freq_control=0, o_step_strobe=0, o_busy=0, o_done=0; latched config and dwell counter cleared. Reset mid-sweep behaves identically, with no done pulse.
- All outputs are registered.
- States: IDLE, DWELL, DONE.
- IDLE:
  - i_start=1 and i_abort=0: latch start, stop, step, dwell (0 becomes 1) and repeat.
  - Next cycle: o_freq_control=i_start_freq, o_step_strobe=1, o_busy=1, dwell counter=0, go to DWELL.
  - Start-to-output latency is 1 cycle.
- DWELL:
  - The counter increments each cycle. Each word is held exactly dwell cycles.
  - At counter == dwell-1, compute next = freq + step in FREQ_WIDTH+1 bits.
    - If carry=0 and next <= stop: o_freq_control <= next[FREQ_WIDTH-1:0], strobe, counter 0.
    - Otherwise, with repeat=1: o_freq_control <= latched start, strobe, counter 0.
    - Otherwise, with repeat=0: go to DONE.
  - The frequency word never wraps through 0.
- DONE: lasts one cycle. o_done=1, o_busy=0, o_step_strobe=0. o_freq_control holds the last word. Next state is IDLE.
- i_abort=1 in any state: next state IDLE, o_busy=0, no o_done, o_freq_control holds its value. Abort together with start in IDLE means start is ignored.
- i_start outside IDLE is ignored. Inputs other than i_abort are not sampled after the latch, so changing them mid-sweep has no effect.
- Boundary cases:
  - step=0: the start word is held indefinitely; repeat and strobes continue every dwell. Only abort or reset ends it.
  - start_freq > stop_freq: the start word is held for one dwell, then DONE (or a repeat restart).
- Output uses unsigned arithmetic only.

Decomposition:
- Shared package ddfs_pkg: sweep_state_t enum (IDLE, DWELL, DONE) and localparam DDFS_FREQ_WIDTH=32, so the DDFS and controller stay aligned.
- No sub-module. The dwell counter and FSM are inline; the block is roughly 150–200 lines.

Test Plan:
- Reset, then start=0x000FFFFF, stop=0x003FFFFF, step=0x00100000, dwell=4, repeat=0, start pulse sampled at edge T:
  - Words 0x000FFFFF, 0x001FFFFF, 0x002FFFFF and 0x003FFFFF, 4 cycles each, from T+1 to T+16.
  - 4 strobes.
  - o_done high only at T+17; o_busy low from T+17.
- Same config with repeat=1: after 0x003FFFFF the word returns to 0x000FFFFF with a strobe and no done pulse. Abort mid-dwell gives IDLE the next cycle, word held, o_done never asserted.
- Overflow guard: start=0xFFE00000, stop=0xFFFFFFFF, step=0x00100000, dwell=1 → 0xFFE00000 then 0xFFF00000, then done. 0x00000000 never appears.
- dwell=0, start=0x10, stop=0x30, step=0x10 → 0x10, 0x20, 0x30, each exactly 1 cycle; strobe high 3 consecutive cycles; done follows.
- i_start pulsed while busy and i_start together with i_abort in IDLE → both ignored; config inputs changed mid-sweep have no effect on the words.
- i_rst asserted mid-sweep → next cycle all outputs 0, state IDLE; a new start then operates normally.
